// File: rtl/ahb_mtx_arb_rr_if.sv
// Signal bundle between the AHB matrix output stage and its round-robin arbiter.
// HREADYM qualifies every transfer: a beat counts only on a rising HCLK edge with HREADYM high.
interface ahb_mtx_arb_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 3
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;
    // Remaining-beat counter, exported for observation.
    logic [3:0]           beat_cnt;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold, beat_cnt
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold, beat_cnt
    );
endinterface

// File: rtl/ahb_mtx_arb_rr.sv
// Round-robin output-stage arbiter for one AHB matrix slave port.
// Fixed-length bursts and locked sequences keep the grant until they complete.
module ahb_mtx_arb_rr #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 3
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_mtx_arb_rr_if.slave     bus
);

    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
        $error("ahb_mtx_arb_rr: NUM_PORTS must be in 2..8");
    end
    if ((1 << PORT_W) < NUM_PORTS) begin : g_bad_port_w
        $error("ahb_mtx_arb_rr: PORT_W too narrow for NUM_PORTS");
    end

    logic [PORT_W-1:0]      r_addr;
    logic                   r_no_port;
    logic [3:0]             r_beat_cnt;

    logic [3:0]             w_beat_load;
    logic [3:0]             w_beat_next;
    logic [2*NUM_PORTS-1:0] w_req_dbl;
    logic [PORT_W:0]        w_shift;
    logic [NUM_PORTS-1:0]   w_req_rot;
    logic                   w_rr_found;
    logic [PORT_W-1:0]      w_rr_pick;
    logic [PORT_W-1:0]      w_addr_next;
    logic                   w_no_port_next;

    always_comb begin
        w_beat_load = 4'd0;
        case (bus.HBURSTM)
            3'b010, 3'b011: w_beat_load = 4'd3;
            3'b100, 3'b101: w_beat_load = 4'd7;
            3'b110, 3'b111: w_beat_load = 4'd15;
            default:        w_beat_load = 4'd0;
        endcase
    end

    // A NONSEQ without HSELM, or an IDLE, terminates any burst early.
    always_comb begin
        w_beat_next = 4'd0;
        if (bus.HSELM && bus.HTRANSM == TRANS_NONSEQ) begin
            w_beat_next = w_beat_load;
        end else if (bus.HTRANSM == TRANS_SEQ && r_beat_cnt != 4'd0) begin
            w_beat_next = r_beat_cnt - 4'd1;
        end else if (bus.HTRANSM == TRANS_BUSY) begin
            w_beat_next = r_beat_cnt;
        end else begin
            w_beat_next = 4'd0;
        end
    end

    // Rotate requests so bit j is port (r_addr + 1 + j) mod NUM_PORTS; the
    // current owner lands on the top bit and is therefore the last choice.
    assign w_req_dbl = {bus.req_port, bus.req_port};
    assign w_shift   = {1'b0, r_addr} + {{PORT_W{1'b0}}, 1'b1};
    assign w_req_rot = NUM_PORTS'(w_req_dbl >> w_shift);

    always_comb begin
        int s;
        w_rr_found = 1'b0;
        w_rr_pick  = r_addr;
        s          = 0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                s = int'(r_addr) + 1 + j;
                if (s >= NUM_PORTS) begin
                    s = s - NUM_PORTS;
                end
                w_rr_found = 1'b1;
                w_rr_pick  = PORT_W'(s);
            end
        end
    end

    always_comb begin
        w_addr_next    = r_addr;
        w_no_port_next = 1'b1;
        if (bus.HMASTLOCKM) begin
            w_no_port_next = 1'b0;
        end else if (w_beat_next != 4'd0) begin
            w_no_port_next = 1'b0;
        end else if (w_rr_found) begin
            w_addr_next    = w_rr_pick;
            w_no_port_next = 1'b0;
        end else if (bus.HSELM) begin
            w_no_port_next = 1'b0;
        end else begin
            w_no_port_next = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr     <= '0;
            r_no_port  <= 1'b1;
            r_beat_cnt <= 4'd0;
        end else if (bus.HREADYM) begin
            r_addr     <= w_addr_next;
            r_no_port  <= w_no_port_next;
            r_beat_cnt <= w_beat_next;
        end
    end

    assign bus.addr_in_port = r_addr;
    assign bus.no_port      = r_no_port;
    assign bus.burst_hold   = (r_beat_cnt != 4'd0);
    assign bus.beat_cnt     = r_beat_cnt;

endmodule

// File: tb/tb_ahb_mtx_arb_rr.sv
// Directed bench for the round-robin matrix arbiter: rotation, bursts, wait states,
// lock, early termination and asynchronous reset mid-burst.
module tb_ahb_mtx_arb_rr;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_WRAP4  = 3'b010;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_INCR16 = 3'b111;

    logic HCLK;
    logic HRESETn;
    int   total;
    int   bad;

    ahb_mtx_arb_rr_if #(.NUM_PORTS(4), .PORT_W(3)) bus ();

    ahb_mtx_arb_rr #(.NUM_PORTS(4), .PORT_W(3)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int addr, input int nop,
                              input int hold, input int beat);
        chk({tag, ".addr"}, 32'(bus.addr_in_port), 32'(addr));
        chk({tag, ".no_port"}, 32'(bus.no_port), 32'(nop));
        chk({tag, ".burst_hold"}, 32'(bus.burst_hold), 32'(hold));
        chk({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(beat));
    endtask

    task automatic drive(input logic [3:0] req, input logic rdy, input logic sel,
                         input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        bus.req_port   = req;
        bus.HREADYM    = rdy;
        bus.HSELM      = sel;
        bus.HTRANSM    = tr;
        bus.HBURSTM    = bu;
        bus.HMASTLOCKM = lk;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int rot_exp [5];
        total = 0;
        bad   = 0;
        rot_exp = '{1, 2, 3, 0, 1};

        // Reset with every input low, then idle bus after release.
        HRESETn = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        #12;
        expect_out("reset", 0, 1, 0, 0);
        #1 HRESETn = 1'b1;
        drive(4'b0000, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        tick();
        expect_out("idle_after_reset", 0, 1, 0, 0);

        // All ports requesting single transfers: strict rotation.
        drive(4'b1111, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("rotate%0d", i), rot_exp[i], 0, 0, 0);
        end

        // Port 1 runs INCR8 against full contention.
        drive(4'b1111, 1'b1, 1'b1, T_NONSEQ, B_INCR8, 1'b0);
        tick();
        expect_out("incr8_nonseq", 1, 0, 1, 7);
        for (int k = 6; k >= 1; k--) begin
            drive(4'b1111, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0);
            tick();
            expect_out($sformatf("incr8_seq%0d", k), 1, 0, 1, k);
        end
        tick();
        expect_out("incr8_handover", 2, 0, 0, 0);

        // Port 2 runs INCR8 with three wait states and one BUSY.
        drive(4'b1111, 1'b1, 1'b1, T_NONSEQ, B_INCR8, 1'b0);
        tick();
        expect_out("ws_nonseq", 2, 0, 1, 7);
        drive(4'b1111, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0);
        tick();
        expect_out("ws_seq6", 2, 0, 1, 6);
        drive(4'b1111, 1'b0, 1'b1, T_SEQ, B_INCR8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("ws_wait%0d", i), 2, 0, 1, 6);
        end
        drive(4'b1111, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0);
        tick();
        expect_out("ws_seq5", 2, 0, 1, 5);
        drive(4'b1111, 1'b1, 1'b1, T_BUSY, B_INCR8, 1'b0);
        tick();
        expect_out("ws_busy", 2, 0, 1, 5);
        drive(4'b1111, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0);
        for (int k = 4; k >= 1; k--) begin
            tick();
            expect_out($sformatf("ws_seq%0d", k), 2, 0, 1, k);
        end
        tick();
        expect_out("ws_handover", 3, 0, 0, 0);

        // Move grant to port 2, then lock it against other requesters.
        drive(4'b0100, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
        tick();
        expect_out("to_port2", 2, 0, 0, 0);
        drive(4'b1011, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("lock%0d", i), 2, 0, 0, 0);
        end
        drive(4'b1011, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
        tick();
        expect_out("unlock", 3, 0, 0, 0);

        // Port 0 WRAP4 terminated early by IDLE.
        drive(4'b0001, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
        tick();
        expect_out("to_port0", 0, 0, 0, 0);
        drive(4'b0010, 1'b1, 1'b1, T_NONSEQ, B_WRAP4, 1'b0);
        tick();
        expect_out("wrap4_nonseq", 0, 0, 1, 3);
        drive(4'b0010, 1'b1, 1'b1, T_SEQ, B_WRAP4, 1'b0);
        tick();
        expect_out("wrap4_seq", 0, 0, 1, 2);
        drive(4'b0010, 1'b1, 1'b1, T_IDLE, B_WRAP4, 1'b0);
        tick();
        expect_out("wrap4_early_term", 1, 0, 0, 0);
        drive(4'b0000, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        expect_out("no_port", 1, 1, 0, 0);

        // Sole requester is the current owner: search wraps back to it.
        drive(4'b0010, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0);
        tick();
        expect_out("sole_owner", 1, 0, 0, 0);

        // Asynchronous reset in the middle of an INCR16.
        drive(4'b0010, 1'b1, 1'b1, T_NONSEQ, B_INCR16, 1'b0);
        tick();
        expect_out("incr16_nonseq", 1, 0, 1, 15);
        drive(4'b0010, 1'b1, 1'b1, T_SEQ, B_INCR16, 1'b0);
        tick();
        expect_out("incr16_seq", 1, 0, 1, 14);
        #3 HRESETn = 1'b0;
        #1;
        expect_out("async_reset", 0, 1, 0, 0);
        tick();
        expect_out("held_in_reset", 0, 1, 0, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive(4'b0100, 1'b1, 1'b1, T_SEQ, B_INCR16, 1'b0);
        tick();
        expect_out("after_reset_free", 2, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_arb_rr.md
Name: ahb_mtx_arb_rr

Overview:
- Round-robin output-stage arbiter for one slave port of the AHB bus matrix.
- Selects which input port drives the shared slave, as a drop-in alternative to the fixed-priority output arbiters.
- Adds burst awareness: a fixed-length burst (INCR4/8/16, WRAP4/8/16) is never split by a port handover.
- Locked sequences are held to completion.

Parameters:
- NUM_PORTS, 4, number of input ports competing for this slave; legal range 2..8.
- PORT_W, 3, width of addr_in_port; must satisfy 2^PORT_W >= NUM_PORTS.

Ports:
- HCLK  input  1  AHB system clock
- HRESETn  input  1  asynchronous active-low reset
- req_port  input  NUM_PORTS  per-input-port request for this slave; bit i = port i
- HREADYM  input  1  transfer done on the slave side; all state updates qualified by it
- HSELM  input  1  slave select of the currently granted port
- HTRANSM  input  2  transfer type of the granted port (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HBURSTM  input  3  burst type of the granted port
- HMASTLOCKM  input  1  locked transfer of the granted port
- addr_in_port  output  PORT_W  index of the granted input port (registered)
- no_port  output  1  high when no input port is granted (registered)
- burst_hold  output  1  high while a fixed-length burst is in progress (beat_cnt != 0)

Behaviour:
- Clock and reset: reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset values: addr_in_port = 0, no_port = 1, beat_cnt = 0, burst_hold = 0.
- Update rule: all registers update only on a rising HCLK edge with HREADYM = 1. With HREADYM = 0 everything holds.
- Latency: the grant changes one cycle after the qualifying edge.
- beat_cnt (4-bit), computed combinationally as beat_cnt_next:
  - If HSELM and HTRANSM = NONSEQ: load 3 for HBURSTM 010/011, 7 for 100/101, 15 for 110/111, else 0 (SINGLE/INCR).
  - Else if HTRANSM = SEQ and beat_cnt != 0: beat_cnt - 1.
  - Else if HTRANSM = BUSY: hold.
  - Else (IDLE, or HSELM low with NONSEQ): 0. This is early termination and clears the hold.
  - beat_cnt <= beat_cnt_next on HREADYM.
- Grant decision, first match wins:
  1. HMASTLOCKM = 1 → hold current grant, no_port_next = 0.
  2. beat_cnt_next != 0 → hold current grant, no_port_next = 0.
  3. Any req_port bit set → round-robin pick, no_port_next = 0.
     - Search order starts at (addr_in_port + 1) mod NUM_PORTS and wraps.
     - The currently granted port is therefore lowest priority.
     - If the current port is the only requester, it keeps the grant.
  4. HSELM = 1 → hold current grant, no_port_next = 0.
  5. Otherwise → no_port_next = 1, addr_in_port holds its value.
- Wrap-around: from port NUM_PORTS-1 the search continues at port 0.
- Requests for indices >= NUM_PORTS do not exist; addr_in_port never exceeds NUM_PORTS-1.
- Simultaneous events:
  - Lock takes priority over burst count.
  - A NONSEQ fixed burst accepted at the same edge as other requests holds the grant, because beat_cnt_next is nonzero.
  - On the edge where the final SEQ beat is accepted (beat_cnt 1 → 0), arbitration is free and handover may occur.
- Reset mid-burst: immediately returns to reset values. There is no residual hold after reset release.
- No combinational path from req_port to the outputs.

Test Plan:
- Reset with all inputs 0 → addr_in_port = 0, no_port = 1, burst_hold = 0. After release with no req and HSELM = 0 → these values persist.
- req_port = 4'b1111 held, HREADYM = 1, HTRANSM = NONSEQ SINGLE every cycle → grant sequence 1, 2, 3, 0, 1 on successive cycles, no_port = 0.
- Port 1 granted issues INCR8 (NONSEQ + 7 SEQ) while req_port = 4'b1111 → grant stays 1 for 8 accepted beats, burst_hold high for 7 cycles, then grant = 2.
- Same INCR8 with HREADYM low for 3 cycles mid-burst, plus one BUSY → beat count is not lost; handover only after the 8th SEQ/NONSEQ beat is accepted.
- Port 2 granted with HMASTLOCKM = 1 for 5 cycles, req_port = 4'b1011 → grant stays 2. Lock drops → grant = 3.
- Port 0 granted, WRAP4 NONSEQ then IDLE after 2 beats (early termination), req_port = 4'b0010 → beat_cnt cleared, grant = 1 next cycle. Then all req = 0 and HSELM = 0 → no_port = 1 with addr_in_port = 1.
